// File: rtl/mono_chip_emu_if.sv
// ============================================================================
// Module      : mono_chip_emu_if
// Description : Bundle of the hit-push and controller read-out signals of the
//               MONOPIX chip emulator.
//               master : pattern source / controller side
//               slave  : emulated chip side
//   hit_we, hit_data   push strobe and hit word
//   hit_full, hit_lost FIFO full (registered) and sticky overflow flag
//   freeze, read       controller FREEZE level and READ request
//   token, data, busy  hits pending, serial MSB-first data, LOAD/SHIFT active
//   read_err_cnt       saturating count of rejected READ edges
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mono_chip_emu_if #(
    parameter int WORD_BITS = 24,
    parameter int ERR_BITS  = 8
);
    logic                 hit_we;
    logic [WORD_BITS-1:0] hit_data;
    logic                 hit_full;
    logic                 hit_lost;
    logic                 freeze;
    logic                 read;
    logic                 token;
    logic                 data;
    logic                 busy;
    logic [ERR_BITS-1:0]  read_err_cnt;

    modport master (
        output hit_we, hit_data, freeze, read,
        input  hit_full, hit_lost, token, data, busy, read_err_cnt
    );

    modport slave (
        input  hit_we, hit_data, freeze, read,
        output hit_full, hit_lost, token, data, busy, read_err_cnt
    );
endinterface

`default_nettype wire

// File: rtl/mono_chip_emu.sv
// ============================================================================
// Module      : mono_chip_emu
// Description : MONOPIX readout-side pixel chip emulator. Hit words are
//               pushed into a circular FIFO; the controller FREEZE/READ
//               sequence is answered with TOKEN and a serial MSB-first word
//               on DATA.
// Ports       : clk   - serialiser clock, all registers on its rising edge
//               rst_n - synchronous reset, active low
//               bus   - mono_chip_emu_if.slave (hit push, FREEZE/READ,
//                       TOKEN/DATA/BUSY, status flags, error counter)
// Options     : MONO_EMU_GRAY_EN - when defined, the LE [15:8] and TE [7:0]
//               fields are Gray-coded when a word is loaded for shifting.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mono_chip_emu #(
    parameter int WORD_BITS  = 24,
    parameter int DEPTH_LOG2 = 4,
    parameter int ERR_BITS   = 8
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    mono_chip_emu_if.slave     bus
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = $clog2(WORD_BITS);
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2
    } state_t;

    state_t                 state, state_nxt;

    logic [WORD_BITS-1:0]   mem [DEPTH];
    logic [DEPTH_LOG2-1:0]  wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]    count, count_nxt, snap;
    logic                   frozen, freeze_d, read_d;
    logic                   token_r, full_r, lost_r;
    logic [WORD_BITS-1:0]   sr, load_word;
    logic [CNT_W-1:0]       bit_cnt;
    logic [ERR_BITS-1:0]    err_cnt;

    logic read_rise, freeze_rise, freeze_fall;
    logic avail, full, pop, push_ok, drop, read_err;

    assign read_rise   = bus.read & ~read_d;
    assign freeze_rise = bus.freeze & ~freeze_d;
    assign freeze_fall = ~bus.freeze & freeze_d;
    // While frozen only the words present at the freeze edge are offered.
    assign avail       = frozen ? (snap != '0) : (count != '0);
    assign full        = (count == FULL_CNT);
    // A pop in the same cycle frees the slot, so a push on a full FIFO is kept.
    assign push_ok     = bus.hit_we & (~full | pop);
    assign drop        = bus.hit_we & full & ~pop;

    always_comb begin
        count_nxt = count;
        if (push_ok && !pop)
            count_nxt = count + 1'b1;
        else if (pop && !push_ok)
            count_nxt = count - 1'b1;
    end

    // Word taken from the FIFO head at LOAD, optionally with Gray timestamps.
    always_comb begin
        load_word = mem[rd_ptr];
`ifdef MONO_EMU_GRAY_EN
        load_word[15:8] = mem[rd_ptr][15:8] ^ (mem[rd_ptr][15:8] >> 1);
        load_word[7:0]  = mem[rd_ptr][7:0]  ^ (mem[rd_ptr][7:0]  >> 1);
`endif
    end

    // FSM next state and control strobes.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        read_err  = 1'b0;
        case (state)
            S_IDLE: begin
                if (read_rise) begin
                    if (avail) state_nxt = S_LOAD;
                    else       read_err  = 1'b1;
                end
            end
            S_LOAD: begin
                pop       = 1'b1;
                read_err  = read_rise;
                state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                read_err = read_rise;
                if (bit_cnt == '0) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Storage array is not reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= bus.hit_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            snap     <= '0;
            frozen   <= 1'b0;
            freeze_d <= 1'b0;
            read_d   <= 1'b0;
            token_r  <= 1'b0;
            full_r   <= 1'b0;
            lost_r   <= 1'b0;
            sr       <= '0;
            bit_cnt  <= '0;
            err_cnt  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            count    <= count_nxt;
            full_r   <= (count_nxt == FULL_CNT);
            if (drop) lost_r <= 1'b1;
            freeze_d <= bus.freeze;
            read_d   <= bus.read;

            // Snapshot excludes a same-cycle push but honours a same-cycle pop.
            if (freeze_rise) begin
                frozen <= 1'b1;
                snap   <= count - {{DEPTH_LOG2{1'b0}}, pop};
            end else if (freeze_fall) begin
                frozen <= 1'b0;
            end else if (frozen && pop && snap != '0) begin
                snap <= snap - 1'b1;
            end

            token_r <= frozen ? (snap != '0) : (count != '0);

            if (read_err && err_cnt != '1)
                err_cnt <= err_cnt + 1'b1;

            if (pop) begin
                sr      <= load_word;
                bit_cnt <= CNT_W'(WORD_BITS-1);
            end else if (state == S_SHIFT) begin
                sr <= sr << 1;
                if (bit_cnt != '0) bit_cnt <= bit_cnt - 1'b1;
            end
        end
    end

    assign bus.data         = (state == S_SHIFT) & sr[WORD_BITS-1];
    assign bus.busy         = (state != S_IDLE);
    assign bus.token        = token_r;
    assign bus.hit_full     = full_r;
    assign bus.hit_lost     = lost_r;
    assign bus.read_err_cnt = err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_mono_chip_emu.sv
// ============================================================================
// Module      : tb_mono_chip_emu
// Description : Directed self-checking bench for mono_chip_emu: push, freeze,
//               read-out timing, overflow, push-during-pop, mid-shift READ,
//               reset mid-word and the optional Gray timestamp coding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mono_chip_emu;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mono_chip_emu_if #(.WORD_BITS(24), .ERR_BITS(8)) bus ();

    mono_chip_emu #(.WORD_BITS(24), .DEPTH_LOG2(4), .ERR_BITS(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Expected on-wire word for a pushed word.
    function automatic logic [23:0] tx_word(input logic [23:0] w);
        logic [23:0] r;
        r = w;
`ifdef MONO_EMU_GRAY_EN
        r[15:8] = w[15:8] ^ {1'b0, w[15:9]};
        r[7:0]  = w[7:0]  ^ {1'b0, w[7:1]};
`endif
        return r;
    endfunction

    function automatic logic [23:0] word_of(input int i);
        return {6'(i + 1), 2'b10, 8'(i * 17 + 3), 8'(8'hF0 ^ 8'(i))};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic push(input logic [23:0] w);
        bus.hit_we   = 1'b1;
        bus.hit_data = w;
        tick();
        bus.hit_we   = 1'b0;
    endtask

    // One READ pulse and capture of the serial word.
    // mid_bit >= 0 raises READ again while that bit is on DATA.
    // load_push pushes push_w in the LOAD cycle (same edge as the pop).
    task automatic read_word(output logic [23:0] w, input bit chk_edges,
                             input int mid_bit, input bit load_push,
                             input logic [23:0] push_w);
        w = '0;
        bus.read = 1'b1;
        tick();                       // edge t: IDLE -> LOAD
        bus.read = 1'b0;
        if (chk_edges) begin
            check("load_busy", {31'b0, bus.busy}, 32'd1);
            check("load_data", {31'b0, bus.data}, 32'd0);
        end
        if (load_push) begin
            bus.hit_we   = 1'b1;
            bus.hit_data = push_w;
        end
        tick();                       // edge t+1: pop, MSB on DATA
        bus.hit_we = 1'b0;
        for (int i = 0; i < 24; i++) begin
            w[23-i]  = bus.data;
            bus.read = (i == mid_bit);
            tick();
        end
        bus.read = 1'b0;
        if (chk_edges) begin
            check("post_data", {31'b0, bus.data}, 32'd0);
            check("post_busy", {31'b0, bus.busy}, 32'd0);
        end
    endtask

    logic [23:0] got;
    logic        any_data;

    initial begin
        bus.hit_we   = 1'b0;
        bus.hit_data = '0;
        bus.freeze   = 1'b0;
        bus.read     = 1'b0;
        do_reset();

        // Reset state
        check("rst_token", {31'b0, bus.token},    32'd0);
        check("rst_data",  {31'b0, bus.data},     32'd0);
        check("rst_busy",  {31'b0, bus.busy},     32'd0);
        check("rst_full",  {31'b0, bus.hit_full}, 32'd0);
        check("rst_lost",  {31'b0, bus.hit_lost}, 32'd0);
        check("rst_err",   {24'b0, bus.read_err_cnt}, 32'd0);

        // Two words under FREEZE, 30-cycle gap between reads
        push(24'hA51234);
        check("tok_lat0", {31'b0, bus.token}, 32'd0);
        push(24'h3F00FF);
        check("tok_lat1", {31'b0, bus.token}, 32'd1);
        bus.freeze = 1'b1;
        tick();
        tick();
        read_word(got, 1'b1, -1, 1'b0, 24'h0);
        check("t1_word0", {8'b0, got}, {8'b0, tx_word(24'hA51234)});
        repeat (30) tick();
        read_word(got, 1'b1, -1, 1'b0, 24'h0);
        check("t1_word1", {8'b0, got}, {8'b0, tx_word(24'h3F00FF)});
        tick();
        check("t1_token0", {31'b0, bus.token}, 32'd0);
        bus.freeze = 1'b0;

        // Snapshot limits the read-out while frozen
        do_reset();
        push(word_of(0));
        bus.freeze = 1'b1;
        tick();
        push(word_of(1));
        push(word_of(2));
        push(word_of(3));
        read_word(got, 1'b0, -1, 1'b0, 24'h0);
        check("t2_word", {8'b0, got}, {8'b0, tx_word(word_of(0))});
        bus.read = 1'b1;
        tick();
        bus.read = 1'b0;
        any_data = 1'b0;
        for (int i = 0; i < 6; i++) begin
            any_data |= bus.data | bus.busy;
            tick();
        end
        check("t2_rej_idle", {31'b0, any_data}, 32'd0);
        check("t2_err",  {24'b0, bus.read_err_cnt}, 32'd1);
        check("t2_tokf", {31'b0, bus.token}, 32'd0);
        bus.freeze = 1'b0;
        tick();
        tick();
        check("t2_tok", {31'b0, bus.token}, 32'd1);
        read_word(got, 1'b0, -1, 1'b0, 24'h0);
        check("t2_next", {8'b0, got}, {8'b0, tx_word(word_of(1))});

        // Overflow: 17 pushes, first 16 retained in order
        do_reset();
        for (int i = 0; i < 17; i++) begin
            push(word_of(i));
            if (i == 14) check("t3_nfull15", {31'b0, bus.hit_full}, 32'd0);
            if (i == 15) begin
                check("t3_full16", {31'b0, bus.hit_full}, 32'd1);
                check("t3_nlost16", {31'b0, bus.hit_lost}, 32'd0);
            end
        end
        check("t3_lost", {31'b0, bus.hit_lost}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            read_word(got, 1'b0, -1, 1'b0, 24'h0);
            check($sformatf("t3_w%0d", i), {8'b0, got}, {8'b0, tx_word(word_of(i))});
        end
        tick();
        check("t3_empty_tok", {31'b0, bus.token},    32'd0);
        check("t3_empty_full", {31'b0, bus.hit_full}, 32'd0);

        // Push coinciding with the pop of a full FIFO (pointers offset by 3)
        do_reset();
        for (int i = 0; i < 3; i++) begin
            push(word_of(100 + i));
            read_word(got, 1'b0, -1, 1'b0, 24'h0);
            check($sformatf("t4_pre%0d", i), {8'b0, got}, {8'b0, tx_word(word_of(100 + i))});
        end
        for (int i = 0; i < 16; i++) push(word_of(200 + i));
        check("t4_full", {31'b0, bus.hit_full}, 32'd1);
        read_word(got, 1'b0, -1, 1'b1, 24'hC0FFEE);
        check("t4_w0", {8'b0, got}, {8'b0, tx_word(word_of(200))});
        check("t4_full_kept", {31'b0, bus.hit_full}, 32'd1);
        check("t4_nlost", {31'b0, bus.hit_lost}, 32'd0);
        for (int i = 1; i < 16; i++) begin
            read_word(got, 1'b0, -1, 1'b0, 24'h0);
            check($sformatf("t4_w%0d", i), {8'b0, got}, {8'b0, tx_word(word_of(200 + i))});
        end
        read_word(got, 1'b0, -1, 1'b0, 24'h0);
        check("t4_new", {8'b0, got}, {8'b0, tx_word(24'hC0FFEE)});
        check("t4_nlost_end", {31'b0, bus.hit_lost}, 32'd0);

        // READ edge mid-shift, then reset mid-word
        do_reset();
        push(24'h5A5A5A);
        push(24'h123456);
        read_word(got, 1'b0, 10, 1'b0, 24'h0);
        check("t5_word", {8'b0, got}, {8'b0, tx_word(24'h5A5A5A)});
        check("t5_err", {24'b0, bus.read_err_cnt}, 32'd1);
        bus.read = 1'b1;
        tick();
        bus.read = 1'b0;
        tick();
        repeat (5) tick();
        check("t5_busy_mid", {31'b0, bus.busy}, 32'd1);
        rst_n = 1'b0;
        tick();
        check("t5_rst_data",  {31'b0, bus.data},  32'd0);
        check("t5_rst_busy",  {31'b0, bus.busy},  32'd0);
        check("t5_rst_token", {31'b0, bus.token}, 32'd0);
        check("t5_rst_err",   {24'b0, bus.read_err_cnt}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Timestamp coding
        do_reset();
        push(24'h00FF80);
        read_word(got, 1'b0, -1, 1'b0, 24'h0);
`ifdef MONO_EMU_GRAY_EN
        check("t6_gray", {8'b0, got}, 32'h000080C0);
`else
        check("t6_plain", {8'b0, got}, 32'h0000FF80);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
